// File: rtl/regfile_wb_ctrl_if.sv
// Write-back request/drain bundle between the execute/memory stages, the
// write-back controller and the register file write port.
interface regfile_wb_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    // Load unit request channel
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;

    // ALU request channel
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    // Register file write port
    logic            wb_stall;
    logic            RegWrite;
    logic [4:0]      WriteReg;
    logic [XLEN-1:0] WriteData;

    // Decode hazard lookup
    logic [4:0]      ReadReg1;
    logic [4:0]      ReadReg2;
    logic            rs1_pending;
    logic            rs2_pending;
    logic [CW-1:0]   wb_count;

    // Requesters, register file and decode side
    modport master (
        output ld_valid, ld_rd, ld_data,
        output alu_valid, alu_rd, alu_data,
        output wb_stall, ReadReg1, ReadReg2,
        input  ld_ready, alu_ready,
        input  RegWrite, WriteReg, WriteData,
        input  rs1_pending, rs2_pending, wb_count
    );

    // Write-back controller side
    modport slave (
        input  ld_valid, ld_rd, ld_data,
        input  alu_valid, alu_rd, alu_data,
        input  wb_stall, ReadReg1, ReadReg2,
        output ld_ready, alu_ready,
        output RegWrite, WriteReg, WriteData,
        output rs1_pending, rs2_pending, wb_count
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: in-order queue of {rd, data} fed by the load unit
// (priority) and the ALU, drained one entry per cycle onto the register file
// write port, with RAW-hazard lookup against decode's source registers.
module regfile_wb_ctrl #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    regfile_wb_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = CW + 1;

    logic [4:0]      r_rd   [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_pop;
    logic [FW-1:0]   w_free;
    logic            w_need_ld;
    logic            w_need_alu;
    logic            w_acc_ld;
    logic            w_acc_alu;
    logic [PW-1:0]   w_alu_idx;
    logic [DEPTH-1:0] w_hit1;
    logic [DEPTH-1:0] w_hit2;

    // Head leaves the queue whenever something is queued and the port is free
    assign w_pop  = (r_count != '0) && !bus.wb_stall;
    // A slot freed by this cycle's pop may be refilled in the same cycle
    assign w_free = FW'(DEPTH) - FW'(r_count) + FW'(w_pop);

    // x0 targets take no slot: they are acknowledged and dropped
    assign w_need_ld  = bus.ld_valid  && (bus.ld_rd  != 5'd0);
    assign w_need_alu = bus.alu_valid && (bus.alu_rd != 5'd0);

    // Load has priority; the ALU only gets a slot left over after the load
    assign bus.ld_ready  = (w_free >= FW'(1));
    assign bus.alu_ready = (w_free >= (FW'(1) + FW'(w_need_ld)));

    assign w_acc_ld  = w_need_ld  && bus.ld_ready;
    assign w_acc_alu = w_need_alu && bus.alu_ready;
    // ALU entry lands behind a same-cycle load entry
    assign w_alu_idx = r_tail + PW'(w_acc_ld);

    assign bus.RegWrite  = w_pop;
    assign bus.WriteReg  = w_pop ? r_rd[r_head]   : 5'd0;
    assign bus.WriteData = w_pop ? r_data[r_head] : '0;
    assign bus.wb_count  = r_count;

    // Per-slot occupancy (distance from head below count) and address match
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PW-1:0] w_offset;
            logic          w_occ;
            assign w_offset   = PW'(gi) - r_head;
            assign w_occ      = (CW'(w_offset) < r_count);
            assign w_hit1[gi] = w_occ && (r_rd[gi] == bus.ReadReg1);
            assign w_hit2[gi] = w_occ && (r_rd[gi] == bus.ReadReg2);
        end
    endgenerate

    assign bus.rs1_pending = (bus.ReadReg1 != 5'd0) && (|w_hit1);
    assign bus.rs2_pending = (bus.ReadReg2 != 5'd0) && (|w_hit2);

    // Entry storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge clock) begin
        if (w_acc_ld) begin
            r_rd[r_tail]   <= bus.ld_rd;
            r_data[r_tail] <= bus.ld_data;
        end
        if (w_acc_alu) begin
            r_rd[w_alu_idx]   <= bus.alu_rd;
            r_data[w_alu_idx] <= bus.alu_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards all queued entries
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_acc_ld) + PW'(w_acc_alu);
            r_count <= r_count + CW'(w_acc_ld) + CW'(w_acc_alu) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_regfile_wb_ctrl;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    regfile_wb_ctrl_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
    regfile_wb_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    ent_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: queued writes in order, at most DEPTH of them
    function automatic bit m_pop();
        return (q.size() != 0) && !bus.wb_stall;
    endfunction
    function automatic int m_free();
        return DEPTH - q.size() + int'(m_pop());
    endfunction
    function automatic bit m_need_ld();
        return bus.ld_valid && (bus.ld_rd != 5'd0);
    endfunction
    function automatic bit m_ld_ready();
        return m_free() >= 1;
    endfunction
    function automatic bit m_alu_ready();
        return m_free() >= 1 + int'(m_need_ld());
    endfunction
    function automatic bit m_pending(input logic [4:0] rr);
        if (rr == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].rd == rr) return 1'b1;
        return 1'b0;
    endfunction

    // Apply inputs, then wait to the falling edge where outputs are sampled
    task automatic drive(input logic lv, input logic [4:0] lr, input logic [XLEN-1:0] ld,
                         input logic av, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                         input logic st);
        bus.ld_valid  = lv;  bus.ld_rd  = lr; bus.ld_data  = ld;
        bus.alu_valid = av;  bus.alu_rd = ar; bus.alu_data = ad;
        bus.wb_stall  = st;
        @(negedge clock);
    endtask

    // Clock edge: retire/accept in the model, then step off the edge
    task automatic advance();
        bit p, la, aa;
        p  = m_pop();
        la = m_need_ld() && m_ld_ready();
        aa = bus.alu_valid && (bus.alu_rd != 5'd0) && m_alu_ready();
        @(posedge clock);
        if (p)  void'(q.pop_front());
        if (la) q.push_back('{bus.ld_rd, bus.ld_data});
        if (aa) q.push_back('{bus.alu_rd, bus.alu_data});
        #1;
    endtask

    task automatic test_reset();
        bus.ReadReg1 = 5'd0; bus.ReadReg2 = 5'd0;
        drive(0, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.RegWrite !== 1'b0) $display("FAIL reset_regwrite: got %b want 0", bus.RegWrite); else n_pass++;
        n_total++; if (bus.WriteReg !== 5'd0) $display("FAIL reset_writereg: got %0d want 0", bus.WriteReg); else n_pass++;
        n_total++; if (bus.WriteData !== '0) $display("FAIL reset_writedata: got %0h want 0", bus.WriteData); else n_pass++;
        n_total++; if (bus.wb_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", bus.wb_count); else n_pass++;
        n_total++; if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1)
            $display("FAIL reset_ready: got ld=%b alu=%b want 1/1", bus.ld_ready, bus.alu_ready); else n_pass++;
        n_total++; if (bus.rs1_pending !== 1'b0 || bus.rs2_pending !== 1'b0)
            $display("FAIL reset_pending: got %b%b want 00", bus.rs1_pending, bus.rs2_pending); else n_pass++;
        reset_n = 1'b1;
        @(posedge clock); #1;
        $display("test_reset done");
    endtask

    task automatic test_single_alu();
        drive(0, 0, 0, 1, 5, 64'h1234, 0);
        n_total++; if (bus.alu_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", bus.alu_ready); else n_pass++;
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd5 || bus.WriteData !== 64'h1234)
            $display("FAIL single_write: got we=%b rd=%0d d=%0h want 1/5/1234", bus.RegWrite, bus.WriteReg, bus.WriteData); else n_pass++;
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.wb_count !== 3'd0 || bus.RegWrite !== 1'b0)
            $display("FAIL single_empty: got cnt=%0d we=%b want 0/0", bus.wb_count, bus.RegWrite); else n_pass++;
        advance();
        $display("test_single_alu done");
    endtask

    task automatic test_dual();
        drive(1, 3, 64'hAA, 1, 4, 64'hBB, 0);
        n_total++; if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1)
            $display("FAIL dual_ready: got ld=%b alu=%b want 1/1", bus.ld_ready, bus.alu_ready); else n_pass++;
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd3 || bus.WriteData !== 64'hAA || bus.wb_count !== 3'd2)
            $display("FAIL dual_first: got we=%b rd=%0d d=%0h cnt=%0d want 1/3/aa/2", bus.RegWrite, bus.WriteReg, bus.WriteData, bus.wb_count); else n_pass++;
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd4 || bus.WriteData !== 64'hBB)
            $display("FAIL dual_second: got we=%b rd=%0d d=%0h want 1/4/bb", bus.RegWrite, bus.WriteReg, bus.WriteData); else n_pass++;
        advance();
        $display("test_dual done");
    endtask

    task automatic test_x0();
        drive(0, 0, 0, 1, 0, 64'hFFFF, 0);
        n_total++; if (bus.alu_ready !== 1'b1) $display("FAIL x0_ready: got %b want 1", bus.alu_ready); else n_pass++;
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            n_total++; if (bus.wb_count !== 3'd0 || bus.RegWrite !== 1'b0)
                $display("FAIL x0_discard: got cnt=%0d we=%b want 0/0", bus.wb_count, bus.RegWrite); else n_pass++;
            advance();
        end
        $display("test_x0 done");
    endtask

    task automatic test_stall_fill();
        drive(1, 10, 64'h1010, 1, 11, 64'h1111, 1);
        advance();
        drive(1, 12, 64'h1212, 1, 13, 64'h1313, 1);
        advance();
        drive(1, 14, 64'h1414, 1, 15, 64'h1515, 1);
        n_total++; if (bus.wb_count !== 3'd4 || bus.ld_ready !== 1'b0 || bus.alu_ready !== 1'b0 || bus.RegWrite !== 1'b0)
            $display("FAIL full_backpressure: got cnt=%0d ld=%b alu=%b we=%b want 4/0/0/0", bus.wb_count, bus.ld_ready, bus.alu_ready, bus.RegWrite); else n_pass++;
        advance();
        drive(1, 14, 64'h1414, 1, 15, 64'h1515, 0);
        n_total++; if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b0 || bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd10)
            $display("FAIL full_pop_accept: got ld=%b alu=%b we=%b rd=%0d want 1/0/1/10", bus.ld_ready, bus.alu_ready, bus.RegWrite, bus.WriteReg); else n_pass++;
        advance();
        for (int i = 0; i < 6 && q.size() != 0; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            n_total++; if (bus.RegWrite !== 1'b1 || bus.WriteReg !== q[0].rd || bus.WriteData !== q[0].data)
                $display("FAIL wrap_order: got we=%b rd=%0d d=%0h want 1/%0d/%0h", bus.RegWrite, bus.WriteReg, bus.WriteData, q[0].rd, q[0].data); else n_pass++;
            advance();
        end
        $display("test_stall_fill done");
    endtask

    task automatic test_hazard();
        bus.ReadReg1 = 5'd7; bus.ReadReg2 = 5'd0;
        drive(0, 0, 0, 1, 7, 64'h77, 1);
        n_total++; if (bus.rs1_pending !== 1'b0) $display("FAIL hazard_same_cycle: got %b want 0", bus.rs1_pending); else n_pass++;
        advance();
        drive(0, 0, 0, 0, 0, 0, 1);
        n_total++; if (bus.rs1_pending !== 1'b1 || bus.rs2_pending !== 1'b0)
            $display("FAIL hazard_queued: got rs1=%b rs2=%b want 1/0", bus.rs1_pending, bus.rs2_pending); else n_pass++;
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.rs1_pending !== 1'b1 || bus.RegWrite !== 1'b1)
            $display("FAIL hazard_head_pop: got rs1=%b we=%b want 1/1", bus.rs1_pending, bus.RegWrite); else n_pass++;
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.rs1_pending !== 1'b0) $display("FAIL hazard_drained: got %b want 0", bus.rs1_pending); else n_pass++;
        advance();
        $display("test_hazard done");
    endtask

    task automatic test_reset_mid();
        bus.ReadReg1 = 5'd1; bus.ReadReg2 = 5'd3;
        drive(1, 1, 64'h1, 1, 2, 64'h2, 1);
        advance();
        drive(1, 3, 64'h3, 0, 0, 0, 1);
        advance();
        drive(0, 0, 0, 0, 0, 0, 1);
        n_total++; if (bus.wb_count !== 3'd3 || bus.rs1_pending !== 1'b1)
            $display("FAIL mid_prefill: got cnt=%0d rs1=%b want 3/1", bus.wb_count, bus.rs1_pending); else n_pass++;
        #2;
        bus.wb_stall = 1'b0;
        reset_n = 1'b0;
        q.delete();
        #1;
        n_total++; if (bus.wb_count !== 3'd0 || bus.RegWrite !== 1'b0 || bus.WriteReg !== 5'd0 || bus.WriteData !== '0)
            $display("FAIL mid_reset_outputs: got cnt=%0d we=%b rd=%0d d=%0h want all 0", bus.wb_count, bus.RegWrite, bus.WriteReg, bus.WriteData); else n_pass++;
        n_total++; if (bus.rs1_pending !== 1'b0 || bus.rs2_pending !== 1'b0)
            $display("FAIL mid_reset_pending: got %b%b want 00", bus.rs1_pending, bus.rs2_pending); else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            n_total++; if (bus.RegWrite !== 1'b0 || bus.wb_count !== 3'd0)
                $display("FAIL post_reset_idle: got we=%b cnt=%0d want 0/0", bus.RegWrite, bus.wb_count); else n_pass++;
            advance();
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        bit e_we; logic [4:0] e_rd; logic [XLEN-1:0] e_d;
        for (int i = 0; i < 400; i++) begin
            bus.ReadReg1 = 5'($urandom_range(0, 7));
            bus.ReadReg2 = 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                  ($urandom_range(0, 9) < 3));
            e_we = m_pop();
            e_rd = e_we ? q[0].rd : 5'd0;
            e_d  = e_we ? q[0].data : '0;
            n_total++; if (bus.ld_ready !== m_ld_ready()) $display("FAIL rnd_ld_ready @%0d: got %b want %b", i, bus.ld_ready, m_ld_ready()); else n_pass++;
            n_total++; if (bus.alu_ready !== m_alu_ready()) $display("FAIL rnd_alu_ready @%0d: got %b want %b", i, bus.alu_ready, m_alu_ready()); else n_pass++;
            n_total++; if (bus.RegWrite !== e_we || bus.WriteReg !== e_rd || bus.WriteData !== e_d)
                $display("FAIL rnd_write @%0d: got %b/%0d/%0h want %b/%0d/%0h", i, bus.RegWrite, bus.WriteReg, bus.WriteData, e_we, e_rd, e_d); else n_pass++;
            n_total++; if (bus.rs1_pending !== m_pending(bus.ReadReg1) || bus.rs2_pending !== m_pending(bus.ReadReg2))
                $display("FAIL rnd_pending @%0d: got %b%b want %b%b", i, bus.rs1_pending, bus.rs2_pending, m_pending(bus.ReadReg1), m_pending(bus.ReadReg2)); else n_pass++;
            n_total++; if (bus.wb_count !== 3'(q.size())) $display("FAIL rnd_count @%0d: got %0d want %0d", i, bus.wb_count, q.size()); else n_pass++;
            advance();
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_dual();
        test_x0();
        test_stall_fill();
        test_hazard();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
